// File: rtl/msu_data_fetch.sv
// MSU-1 data-port streamer: prefetches 16-bit words from the data file into a
// byte FIFO and presents the head byte to the $2001 read port.
module msu_data_fetch #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        msu_data_seek,
   input  logic [31:0] msu_data_addr,
   output logic [7:0]  msu_data_in,
   output logic        msu_status_data_busy,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_data
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   // HOLD is the "waiting for space" flavour of WAIT: no request outstanding.
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FLUSH} state_t;

   state_t                state, state_nx;
   logic [7:0]            fifo [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr1;
   logic [CW-1:0]         count, count_nx, free_nx;
   logic [7:0]            debt, debt_nx;
   logic                  skip_first;
   logic [31:0]           fetch_addr, fetch_nx, addr_q;
   logic [7:0]            last_q;
   logic                  pop_evt, pop_ok, take, push0, push1;
   logic [1:0]            push_n;

   // Pop detection, byte acceptance with underrun debt, FIFO occupancy
   always_comb begin
      pop_evt = (msu_data_addr != addr_q) && !msu_data_seek;
      pop_ok  = pop_evt && (count != '0);
      take    = (state == S_WAIT) && mem_ack && !msu_data_seek;
      push0   = 1'b0;
      push1   = 1'b0;
      debt_nx = debt;
      if (take) begin
         if (!skip_first) begin
            if (debt_nx != '0) debt_nx = debt_nx - 8'd1;
            else               push0   = 1'b1;
         end
         if (debt_nx != '0) debt_nx = debt_nx - 8'd1;
         else               push1   = 1'b1;
      end
      if (pop_evt && (count == '0) && (debt_nx != 8'hFF)) debt_nx = debt_nx + 8'd1;
      if (msu_data_seek) debt_nx = '0;
      push_n   = {1'b0, push0} + {1'b0, push1};
      count_nx = count + CW'(push_n) - CW'(pop_ok);
      if (msu_data_seek) count_nx = '0;
      free_nx  = CW'(DEPTH) - count_nx;
      wr_ptr1  = wr_ptr + 1'b1;
   end

   // Next-state and fetch address; a seek overrides every other transition
   always_comb begin
      state_nx = state;
      fetch_nx = fetch_addr;
      case (state)
         S_IDLE:  state_nx = S_IDLE;
         S_REQ:   state_nx = S_WAIT;
         S_WAIT:  if (mem_ack) begin
                     fetch_nx = fetch_addr + 32'd2;
                     state_nx = (free_nx >= CW'(2)) ? S_REQ : S_HOLD;
                  end
         S_HOLD:  if (free_nx >= CW'(2)) state_nx = S_REQ;
         S_FLUSH: if (mem_ack) state_nx = S_REQ;
         default: state_nx = S_IDLE;
      endcase
      if (msu_data_seek) begin
         fetch_nx = {msu_data_addr[31:1], 1'b0};
         state_nx = ((state == S_WAIT || state == S_FLUSH) && !mem_ack) ? S_FLUSH : S_REQ;
      end
   end

   // State, pointers, counters and the registered memory address
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= S_IDLE;
         count      <= '0;
         debt       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         skip_first <= 1'b0;
         fetch_addr <= '0;
         addr_q     <= '0;
         last_q     <= '0;
         mem_addr   <= '0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         debt       <= debt_nx;
         fetch_addr <= fetch_nx;
         addr_q     <= msu_data_addr;
         last_q     <= msu_data_in;
         if (state_nx == S_REQ) mem_addr <= fetch_nx;
         if (msu_data_seek)  skip_first <= msu_data_addr[0];
         else if (take)      skip_first <= 1'b0;
         if (msu_data_seek) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(push_n);
            rd_ptr <= rd_ptr + DEPTH_LOG2'(pop_ok);
         end
      end
   end

   // FIFO storage; low byte lands before high byte
   always_ff @(posedge CLK) begin
      if (!RESET && !msu_data_seek) begin
         if (push0) fifo[wr_ptr] <= mem_data[7:0];
         if (push1) fifo[push0 ? wr_ptr1 : wr_ptr] <= mem_data[15:8];
      end
   end

   // Outputs: head byte (held when empty), busy, one-cycle read strobe
   always_comb begin
      msu_data_in          = (count != '0) ? fifo[rd_ptr] : last_q;
      msu_status_data_busy = (state != S_IDLE) && ((count == '0) || (debt != '0));
      mem_rd               = (state == S_REQ);
   end

endmodule

// File: tb/tb_msu_data_fetch.sv
// Directed bench for msu_data_fetch with an auto/manual memory responder.
module tb_msu_data_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        seek = 1'b0;
   logic [31:0] addr = '0;
   logic [7:0]  data_in;
   logic        busy, mem_rd, mem_ack = 1'b0;
   logic [31:0] mem_addr;
   logic [15:0] mem_data = '0;

   int unsigned n_chk = 0, n_err = 0;
   bit          auto_en = 1'b0;
   int unsigned ack_lat = 3;
   bit          mbusy = 1'b0;
   int unsigned lat_cnt = 0, n_req = 0;
   logic [31:0] req_addr = '0;

   msu_data_fetch #(.DEPTH_LOG2(4)) dut (
      .CLK(clk), .RESET(rst), .msu_data_seek(seek), .msu_data_addr(addr),
      .msu_data_in(data_in), .msu_status_data_busy(busy), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data));

   always #5 clk = ~clk;

   function automatic logic [15:0] word_at(input logic [31:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      return {lo + 8'd1, lo};
   endfunction

   // memory model: byte value = address[7:0]
   always @(negedge clk) begin
      if (auto_en) begin
         mem_ack = 1'b0;
         if (mbusy) begin
            if (lat_cnt == 0) begin
               mem_ack  = 1'b1;
               mem_data = word_at(req_addr);
               mbusy    = 1'b0;
            end else lat_cnt--;
         end
         if (mem_rd) begin
            req_addr = mem_addr;
            mbusy    = 1'b1;
            lat_cnt  = ack_lat - 1;
            n_req++;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_seek(input logic [31:0] a);
      addr = a; seek = 1'b1; n_req = 0;
      @(negedge clk);
      seek = 1'b0;
   endtask

   task automatic man_ack(input logic [15:0] d);
      mem_ack = 1'b1; mem_data = d;
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   task automatic pop;
      addr = addr + 32'd1;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned rd_seen, busy_seen, nz_seen;
      bit done;
      cyc(3);
      rst = 1'b0;
      cyc(1);
      check_val("rst_data", data_in, 8'h00);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_rd", mem_rd, 1'b0);
      check_val("rst_addr", mem_addr, 32'h0);

      // aligned seek, latency 3, fill to depth
      auto_en = 1'b1; ack_lat = 3;
      do_seek(32'h100);
      check_val("s1_rd", mem_rd, 1'b1);
      check_val("s1_addr", mem_addr, 32'h100);
      check_val("s1_busy", busy, 1'b1);
      cyc(3);
      check_val("s1_busy_m", busy, 1'b1);
      cyc(1);
      check_val("s1_busy_fall", busy, 1'b0);
      check_val("s1_data", data_in, 8'h00);
      check_val("s1_rd2", mem_rd, 1'b1);
      check_val("s1_addr2", mem_addr, 32'h102);
      cyc(56);
      check_val("s1_nreq", n_req, 8);
      check_val("s1_hold_rd", mem_rd, 1'b0);
      check_val("s1_hold_data", data_in, 8'h00);

      // odd seek, then twenty pops
      do_seek(32'h201);
      check_val("s2_addr", mem_addr, 32'h200);
      cyc(4);
      check_val("s2_data", data_in, 8'h01);
      check_val("s2_busy", busy, 1'b0);
      cyc(40);
      for (int i = 0; i < 20; i++) begin
         pop();
         check_val($sformatf("s2_pop%0d", i), data_in, 8'h02 + 8'(i));
         cyc(2);
      end
      cyc(40);

      // seek while a request is outstanding, stale ack
      auto_en = 1'b0;
      do_seek(32'h300);
      cyc(1);
      do_seek(32'h400);
      check_val("s3_flush_rd", mem_rd, 1'b0);
      cyc(2);
      man_ack(16'hAAAA);
      check_val("s3_rd", mem_rd, 1'b1);
      check_val("s3_addr", mem_addr, 32'h400);
      check_val("s3_hold_last", data_in, 8'h15);
      check_val("s3_busy", busy, 1'b1);
      cyc(1);
      man_ack(word_at(32'h400));
      check_val("s3_data", data_in, 8'h00);
      check_val("s3_busy_fall", busy, 1'b0);
      check_val("s3_addr2", mem_addr, 32'h402);

      // seek coincident with ack
      cyc(1);
      addr = 32'h500; seek = 1'b1; mem_ack = 1'b1; mem_data = 16'h0302;
      @(negedge clk);
      seek = 1'b0; mem_ack = 1'b0;
      check_val("s4_rd", mem_rd, 1'b1);
      check_val("s4_addr", mem_addr, 32'h500);
      check_val("s4_busy", busy, 1'b1);
      cyc(1);
      man_ack(word_at(32'h500));
      check_val("s4_data", data_in, 8'h00);
      check_val("s4_busy_fall", busy, 1'b0);

      // underrun: three pops while empty
      auto_en = 1'b1; ack_lat = 40;
      do_seek(32'h300);
      pop(); pop(); pop();
      check_val("s5_debt", dut.debt, 8'd3);
      check_val("s5_busy", busy, 1'b1);
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      check_val("s5_done", done, 1'b1);
      check_val("s5_data", data_in, 8'h03);

      // reset while WAIT, late ack ignored
      cyc(2);
      addr = '0; rst = 1'b1;
      @(negedge clk);
      check_val("s6_data", data_in, 8'h00);
      check_val("s6_busy", busy, 1'b0);
      check_val("s6_rd", mem_rd, 1'b0);
      check_val("s6_addr", mem_addr, 32'h0);
      rst = 1'b0;
      rd_seen = 0; busy_seen = 0; nz_seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (mem_rd) rd_seen++;
         if (busy) busy_seen++;
         if (data_in != 8'h00) nz_seen++;
      end
      check_val("s6_no_rd", rd_seen, 0);
      check_val("s6_no_busy", busy_seen, 0);
      check_val("s6_no_push", nz_seen, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
